// File: rtl/stopwatch_ctrl_if.sv
// Stopwatch control bundle: button levels in, counter/display controls out.
// master drives the buttons, slave is the controller.
interface stopwatch_ctrl_if;
  logic       btn_ss;
  logic       btn_lr;
  logic       cnt_en;
  logic       cnt_clr;
  logic       disp_freeze;
  logic [1:0] state;

  modport master (
    output btn_ss,
    output btn_lr,
    input  cnt_en,
    input  cnt_clr,
    input  disp_freeze,
    input  state
  );

  modport slave (
    input  btn_ss,
    input  btn_lr,
    output cnt_en,
    output cnt_clr,
    output disp_freeze,
    output state
  );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Two-button stopwatch controller: debounce filters, press events, FSM.
// Optional macro LONG_PRESS_CLR_EN adds a long-hold lap/reset clear.
module stopwatch_ctrl #(
  parameter int unsigned STABLE_CYCLES = 16,
  parameter int unsigned LONG_CYCLES   = 1000
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    LAP   = 2'b11
  } state_t;

  localparam logic [15:0] CNT_MAX = 16'(STABLE_CYCLES - 1);

  // index 0 = start/stop, index 1 = lap/reset
  logic [1:0]       raw;
  logic [1:0][15:0] fcnt_q, fcnt_d;
  logic [1:0]       filt_q, filt_d;
  logic [1:0]       press_q, press_d;
  logic             long_evt;

  state_t state_q, state_d;
  logic   clr_q, clr_d;

  assign raw = {bus.btn_lr, bus.btn_ss};

  // Debounce: count while raw differs, accept it on the final count.
  // Press pulse is registered alongside the accepted rising level.
  always_comb begin
    fcnt_d  = fcnt_q;
    filt_d  = filt_q;
    press_d = 2'b00;
    for (int i = 0; i < 2; i++) begin
      if (raw[i] == filt_q[i]) begin
        fcnt_d[i] = 16'd0;
      end else if (fcnt_q[i] >= CNT_MAX) begin
        filt_d[i]  = raw[i];
        fcnt_d[i]  = 16'd0;
        press_d[i] = raw[i];
      end else begin
        fcnt_d[i] = fcnt_q[i] + 16'd1;
      end
    end
  end

  // Filter and press-event registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt_q  <= '0;
      filt_q  <= '0;
      press_q <= '0;
    end else begin
      fcnt_q  <= fcnt_d;
      filt_q  <= filt_d;
      press_q <= press_d;
    end
  end

`ifdef LONG_PRESS_CLR_EN
  localparam int LW = $clog2(LONG_CYCLES + 1);
  localparam logic [LW-1:0] LMAX  = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] LFIRE = LW'(LONG_CYCLES - 1);

  logic [LW-1:0] lcnt_q, lcnt_d;

  // Hold-length counter for the filtered lap/reset level; saturates.
  always_comb begin
    lcnt_d = lcnt_q;
    if (!filt_q[1]) begin
      lcnt_d = '0;
    end else if (lcnt_q != LMAX) begin
      lcnt_d = lcnt_q + LW'(1);
    end
  end

  // Long-press counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      lcnt_q <= '0;
    end else begin
      lcnt_q <= lcnt_d;
    end
  end

  assign long_evt = filt_q[1] && (lcnt_q == LFIRE);
`else
  assign long_evt = 1'b0;
`endif

  // Next state and clear pulse; start/stop wins over lap/reset.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    if (long_evt) begin
      state_d = IDLE;
      clr_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (press_q[0]) state_d = RUN;
          else if (press_q[1]) clr_d = 1'b1;
        end
        RUN: begin
          if (press_q[0]) state_d = PAUSE;
          else if (press_q[1]) state_d = LAP;
        end
        LAP: begin
          if (press_q[0]) state_d = PAUSE;
          else if (press_q[1]) state_d = RUN;
        end
        PAUSE: begin
          if (press_q[0]) begin
            state_d = RUN;
          end else if (press_q[1]) begin
            state_d = IDLE;
            clr_d   = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and clear-pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      clr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.cnt_en      = (state_q == RUN) || (state_q == LAP);
  assign bus.disp_freeze = (state_q == LAP);
  assign bus.cnt_clr     = clr_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl, STABLE_CYCLES=4, LONG_CYCLES=20.
// Long-press expectations follow LONG_PRESS_CLR_EN.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;

  stopwatch_ctrl_if bus ();

  stopwatch_ctrl #(
    .STABLE_CYCLES (4),
    .LONG_CYCLES   (20)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [1:0] obs,
                     input logic [1:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [1:0] st,
                         input logic en,
                         input logic clr,
                         input logic frz);
    chk({tag, ".state"}, bus.state, st);
    chk({tag, ".en"}, {1'b0, bus.cnt_en}, {1'b0, en});
    chk({tag, ".clr"}, {1'b0, bus.cnt_clr}, {1'b0, clr});
    chk({tag, ".frz"}, {1'b0, bus.disp_freeze}, {1'b0, frz});
  endtask

  task automatic press(input logic ss, input logic lr);
    bus.btn_ss = ss;
    bus.btn_lr = lr;
    repeat (6) tick();
    bus.btn_ss = 1'b0;
    bus.btn_lr = 1'b0;
    repeat (6) tick();
  endtask

  initial begin
    bus.btn_ss = 1'b0;
    bus.btn_lr = 1'b0;
    rst = 1'b1;
    repeat (2) tick();
    chk_all("reset", 2'b00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    tick();

    // 3-cycle glitch must not be accepted
    bus.btn_ss = 1'b1;
    repeat (3) tick();
    bus.btn_ss = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_all("glitch", 2'b00, 1'b0, 1'b0, 1'b0);
    end

    // clean 10-cycle press: RUN exactly 5 cycles after raw rise
    bus.btn_ss = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k < 5) chk_all("ss_pre", 2'b00, 1'b0, 1'b0, 1'b0);
      else chk_all("ss_run", 2'b01, 1'b1, 1'b0, 1'b0);
    end
    bus.btn_ss = 1'b0;
    repeat (6) tick();
    chk_all("ss_held_once", 2'b01, 1'b1, 1'b0, 1'b0);

    // RUN -> LAP -> RUN
    press(1'b0, 1'b1);
    chk_all("lap", 2'b11, 1'b1, 1'b0, 1'b1);
    press(1'b0, 1'b1);
    chk_all("lap_back", 2'b01, 1'b1, 1'b0, 1'b0);

    // RUN -> PAUSE
    press(1'b1, 1'b0);
    chk_all("pause", 2'b10, 1'b0, 1'b0, 1'b0);

    // PAUSE -> IDLE, clear pulse for exactly one cycle
    bus.btn_lr = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 5) chk_all("p2i_pre", 2'b10, 1'b0, 1'b0, 1'b0);
      else if (k == 5) chk_all("p2i_clr", 2'b00, 1'b0, 1'b1, 1'b0);
      else chk_all("p2i_post", 2'b00, 1'b0, 1'b0, 1'b0);
    end
    bus.btn_lr = 1'b0;
    repeat (6) tick();

    // both buttons together in IDLE: ss wins, no clear
    bus.btn_ss = 1'b1;
    bus.btn_lr = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k < 5) chk_all("both_pre", 2'b00, 1'b0, 1'b0, 1'b0);
      else chk_all("both_run", 2'b01, 1'b1, 1'b0, 1'b0);
    end
    bus.btn_ss = 1'b0;
    bus.btn_lr = 1'b0;
    repeat (6) tick();
    chk_all("both_no_queue", 2'b01, 1'b1, 1'b0, 1'b0);

    // reset in LAP with ss held through it
    press(1'b0, 1'b1);
    chk_all("lap2", 2'b11, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    bus.btn_ss = 1'b1;
    tick();
    chk_all("rst_lap", 2'b00, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k < 5) chk_all("rst_pre", 2'b00, 1'b0, 1'b0, 1'b0);
      else chk_all("rst_run", 2'b01, 1'b1, 1'b0, 1'b0);
    end
    bus.btn_ss = 1'b0;
    repeat (6) tick();

    // lr held 30 cycles in RUN
    bus.btn_lr = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      if (k < 5) begin
        chk_all("long_pre", 2'b01, 1'b1, 1'b0, 1'b0);
      end else if (k < 24) begin
        chk_all("long_lap", 2'b11, 1'b1, 1'b0, 1'b1);
      end else begin
`ifdef LONG_PRESS_CLR_EN
        chk_all("long_idle", 2'b00, 1'b0, (k == 24), 1'b0);
`else
        chk_all("long_stay", 2'b11, 1'b1, 1'b0, 1'b1);
`endif
      end
    end
    bus.btn_lr = 1'b0;
    repeat (6) tick();
`ifdef LONG_PRESS_CLR_EN
    chk_all("long_end", 2'b00, 1'b0, 1'b0, 1'b0);
`else
    chk_all("long_end", 2'b11, 1'b1, 1'b0, 1'b1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
